md_sched: RTL and testbench

Multi-cycle multiply/divide scheduler for the E stage. It owns the HI/LO register pair and sequences multiply, iterative radix-2 divide and mthi/mtlo writes. It drives the busy flag consumed by pause control to stall mfhi/mflo and new md ops, and aborts cleanly on an exception/interrupt flush.

---
 rtl/md_pkg.sv | 52 +++++
 rtl/md_div_core.sv | 44 ++++
 rtl/md_sched.sv | 153 +++++++++++++++
 tb/tb_md_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide scheduler: op codes, FSM states, counter sizing.
// Optional madd/maddu/msub/msubu support is enabled by defining MD_MADD_EN.
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd8;
  localparam logic [3:0] MD_MADDU = 4'd9;
  localparam logic [3:0] MD_MSUB  = 4'd10;
  localparam logic [3:0] MD_MSUBU = 4'd11;

  localparam int DIV_CYCLES = 33;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdState_e;

  function automatic logic isMulOp(input logic [3:0] op);
`ifdef MD_MADD_EN
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
    return (op == MD_MULT) || (op == MD_MULTU);
`endif
  endfunction

  function automatic logic isDivOp(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic mulIsSigned(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  // Accumulate/subtract ops can only be latched when MD_MADD_EN admits them.
  function automatic logic isAccOp(input logic [3:0] op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  function automatic logic isSubOp(input logic [3:0] op);
    return (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

endpackage

// File: rtl/md_div_core.sv
// 32-iteration restoring unsigned divider; load captures operands, each step retires one quotient bit.
// Latency is 32 step cycles after load; no backpressure, the caller paces load/step.
module md_div_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] dvsr;
  logic [32:0] remShift;
  logic [32:0] diff;

  always_comb begin
    remShift = {remainder, quotient[31]};
    diff     = remShift - {1'b0, dvsr};
  end

  // The quotient register doubles as the dividend shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quotient  <= '0;
      remainder <= '0;
      dvsr      <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvsr      <= divisor;
    end else if (step) begin
      if (!diff[32]) begin
        remainder <= diff[31:0];
        quotient  <= {quotient[30:0], 1'b1};
      end else begin
        remainder <= remShift[31:0];
        quotient  <= {quotient[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/md_sched.sv
// E-stage mult/div scheduler owning HI/LO; MUL_CYCLES / 33-cycle latency, busy stalls the pipe, flush aborts.
// Define MD_MADD_EN to add madd/maddu/msub/msubu; starts while busy are ignored.
module md_sched
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdState_e         state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      opA;
  logic [31:0]      opB;
  logic [3:0]       mulOp;
  logic             qNeg;
  logic             rNeg;
  logic             divZero;

  logic             accept;
  logic             divSigned;
  logic             rsNeg;
  logic             rtNeg;
  logic [31:0]      absRs;
  logic [31:0]      absRt;
  logic             divLoad;
  logic             divStep;
  logic [31:0]      quot;
  logic [31:0]      rem;
  logic [63:0]      aExt;
  logic [63:0]      bExt;
  logic [63:0]      product;
  logic [63:0]      acc;
  logic [63:0]      mulRes;

  always_comb begin
    accept    = (state == IDLE) && start && !flush;
    divSigned = (op == MD_DIV);
    rsNeg     = divSigned && rs_val[31];
    rtNeg     = divSigned && rt_val[31];
    absRs     = rsNeg ? (~rs_val + 32'd1) : rs_val;
    absRt     = rtNeg ? (~rt_val + 32'd1) : rt_val;
    divLoad   = accept && isDivOp(op);
    divStep   = (state == DIV) && !flush;
    // Sign-extending to 64 bits makes the truncated product correct for both signednesses.
    aExt      = {{32{mulIsSigned(mulOp) & opA[31]}}, opA};
    bExt      = {{32{mulIsSigned(mulOp) & opB[31]}}, opB};
    product   = aExt * bExt;
    acc       = isAccOp(mulOp) ? {hi, lo} : 64'd0;
    mulRes    = isSubOp(mulOp) ? (acc - product) : (acc + product);
  end

  md_div_core u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (divLoad),
    .step      (divStep),
    .dividend  (absRs),
    .divisor   (absRt),
    .quotient  (quot),
    .remainder (rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      opA     <= '0;
      opB     <= '0;
      mulOp   <= MD_MULT;
      qNeg    <= 1'b0;
      rNeg    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (op == MD_MTHI) begin
                hi <= rs_val;
              end else if (op == MD_MTLO) begin
                lo <= rs_val;
              end else if (isMulOp(op)) begin
                opA   <= rs_val;
                opB   <= rt_val;
                mulOp <= op;
                cnt   <= CNT_W'(MUL_CYCLES - 1);
                busy  <= 1'b1;
                state <= MUL;
              end else if (isDivOp(op)) begin
                opA     <= rs_val;
                qNeg    <= rsNeg ^ rtNeg;
                rNeg    <= rsNeg;
                divZero <= (rt_val == 32'd0);
                cnt     <= CNT_W'(DIV_CYCLES - 2);
                busy    <= 1'b1;
                state   <= DIV;
              end
            end
          end
          MUL: begin
            if (cnt == '0) begin
              {hi, lo} <= mulRes;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          DIV: begin
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - CNT_W'(1);
          end
          FIX: begin
            // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000, positive sign.
            if (divZero) begin
              lo <= 32'hFFFF_FFFF;
              hi <= opA;
            end else begin
              lo <= qNeg ? (~quot + 32'd1) : quot;
              hi <= rNeg ? (~rem + 32'd1) : rem;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: mult/div results, latency, flush, async reset and the MD_MADD_EN ops.
module tb_md_sched;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;

  md_sched #(.MUL_CYCLES(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start cycle, then scramble operands so latching is exercised.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    tick();
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  task automatic waitIdle(input int n0, output int n);
    n = n0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] eHi,
                       input logic [31:0] eLo);
    int n;
    issue(o, a, b);
    waitIdle(0, n);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(eHi));
    chk({tag, "_lo"}, 64'(lo), 64'(eLo));
    tick();
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int donePulses;
    reset  = 1'b0;
    start  = 1'b0;
    op     = 4'd0;
    rs_val = '0;
    rt_val = '0;
    flush  = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    #10 reset = 1'b1;
    tick();

    // mult 7 * -3, with a second start held into the busy window that must be ignored.
    start  = 1'b1;
    op     = MD_MULT;
    rs_val = 32'd7;
    rt_val = 32'hFFFF_FFFD;
    tick();
    chk("mult_busy_n", 64'(busy), 64'd1);
    op     = MD_MULTU;
    rs_val = 32'd2;
    rt_val = 32'd3;
    tick();
    start  = 1'b0;
    waitIdle(1, n);
    chk("mult_lat", 64'(n), 64'd5);
    chk("mult_done", 64'(done), 64'd1);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
    tick();
    chk("mult_done_drop", 64'(done), 64'd0);

    runOp("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    runOp("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("div_negrt", MD_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    runOp("divu", MD_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    runOp("div_zero", MD_DIV, 32'h1234_5678, 32'd0, 33, 32'h1234_5678, 32'hFFFF_FFFF);
    runOp("divu_zero", MD_DIVU, 32'h8000_0003, 32'd0, 33, 32'h8000_0003, 32'hFFFF_FFFF);
    runOp("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

    // mthi / mtlo: single-edge writes, never busy.
    issue(MD_MTHI, 32'hA, 32'd0);
    chk("mthi_hi", 64'(hi), 64'hA);
    chk("mthi_busy", 64'(busy), 64'd0);
    issue(MD_MTLO, 32'hB, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'hB);
    chk("mtlo_busy", 64'(busy), 64'd0);
    chk("mtlo_done", 64'(done), 64'd0);

    // divu flushed at cycle 10: no result, no done.
    issue(MD_DIVU, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    chk("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    donePulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) donePulses++;
      tick();
    end
    chk("flush_done", 64'(donePulses), 64'd0);
    chk("flush_hi", 64'(hi), 64'hA);
    chk("flush_lo", 64'(lo), 64'hB);

    // flush beats a same-cycle start, including mthi.
    flush  = 1'b1;
    start  = 1'b1;
    op     = MD_MULT;
    rs_val = 32'd3;
    rt_val = 32'd3;
    tick();
    chk("flush_vs_mult", 64'(busy), 64'd0);
    op     = MD_MTHI;
    rs_val = 32'h55;
    tick();
    chk("flush_vs_mthi", 64'(hi), 64'hA);
    flush = 1'b0;
    start = 1'b0;
    tick();

    // Async reset in the middle of a divide clears everything without a clock edge.
    issue(MD_DIV, 32'd100, 32'd3);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    #1 reset = 1'b1;
    tick();

    issue(MD_MTLO, 32'd5, 32'd0);
    chk("pre_madd_lo", 64'(lo), 64'd5);
`ifdef MD_MADD_EN
    runOp("madd", MD_MADD, 32'd3, 32'd4, 5, 32'd0, 32'h11);
    runOp("msub", MD_MSUB, 32'd2, 32'd3, 5, 32'd0, 32'hB);
    runOp("msubu", MD_MSUBU, 32'd1, 32'd12, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    issue(MD_MADD, 32'd3, 32'd4);
    chk("madd_off_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("madd_off_lo", 64'(lo), 64'd5);
    chk("madd_off_hi", 64'(hi), 64'd0);
    chk("madd_off_done", 64'(done), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
